mipi_lane_aligner: RTL and testbench
====================================

# mipi_lane_aligner

Parametrised multi-lane MIPI D-PHY HS receive aligner. It takes 8-bit deserialized words from NUM_LANES per-lane deserializers, all on the common byte clock. For each lane it finds the HS sync byte at any bit offset and absorbs inter-lane skew of up to SKEW_DEPTH-1 byte clocks. Sits between the per-lane deserializers and the CSI-2 packet layer, and emits one lane-aligned word per byte clock.

## Interface
- NUM_LANES, 2: data lanes, 1..4.
- SYNC_BYTE, 8'hB8: HS leader sync pattern.
- SKEW_DEPTH, 4: per-lane skew FIFO depth, power of two, 2..8; maximum tolerated skew is SKEW_DEPTH-1 clocks.
- SETTLE_W, 8: width of the settle counter.
- TIMEOUT, 255: SYNC-state cycle limit, used only with MIPI_SYNC_TIMEOUT_EN.
- clk  in  1  byte clock, shared by all lanes.
- resetb  in  1  reset, asynchronous, active-low.
- q_in  in  NUM_LANES*8  raw deserializer words; lane k is q_in[8k+7:8k].
- lp_p, lp_n  in  NUM_LANES each  asynchronous LP line levels per lane.
- lane_polarity  in  NUM_LANES  1 = invert lane bits before search.
- hs_settle  in  SETTLE_W  required LP-00 dwell in clocks; quasi-static.
- we  out  1  data valid.
- data  out  NUM_LANES*8  aligned bytes; lane k is data[8k+7:8k].
- sof  out  1  pulse with the first valid word of a burst, which holds the sync bytes.
- sync_err  out  1  one-cycle pulse when alignment is abandoned.

## Operation
- LP inputs pass through a 2-flop synchronizer, giving lp00 = all lanes {p,n}==00.
- Each lane registers q0<=q_in and q1<=q0. The window is w={q1,q0}^{16{pol}}. The candidate at offset s (0..7) is w[15-s -: 8]; the older word is in the MSBs.
- FSM states:
  - ST_IDLE: settle counter cleared; go to ST_SETTLE when lp00.
  - ST_SETTLE: counter increments while lp00. If !lp00, go to ST_IDLE. When counter == hs_settle, go to ST_SYNC. hs_settle=0 means one cycle.
  - ST_SYNC: each unlocked lane tests its 8 offsets. The lowest matching offset wins. The lane latches the offset, sets locked, and starts writing aligned bytes into its FIFO, beginning with the sync byte. The skew timer starts at the first lock.
    - When all lanes are locked, go to ST_STREAM.
    - If the skew timer reaches SKEW_DEPTH with any lane unlocked: sync_err pulse, all FIFOs flushed, go to ST_IDLE.
    - If !lp00, go to ST_IDLE with no sync_err.
  - ST_STREAM: all FIFOs pop together every clock and each locked lane keeps writing. we=1, data = FIFO heads, and sof=1 on the first word only. If !lp00, go to ST_IDLE: we=0 from the next clock and all FIFOs flushed; the trailing bytes are discarded.
- FIFO occupancy never exceeds SKEW_DEPTH, so there is no overflow path. Pointers wrap modulo SKEW_DEPTH.
- Simultaneous lock of all lanes is zero skew and goes directly to ST_STREAM.
- Reset mid-burst returns to ST_IDLE with all outputs at 0.

## Timing
- Reset values: we=0, sof=0, sync_err=0, data=0, state ST_IDLE, FIFOs empty, all locks clear.
- LP-change to FSM reaction is 2 clocks (synchronizer).
- A byte on q_in at cycle n is in the window at n+2. Match at cycle m: FIFO write at edge m+1.
- sof/we: 2 clocks after the window cycle in which the last lane matched.
- Steady-state q_in to data latency = 4 + (latest lock − own lock) clocks.

## Configuration
- MIPI_SYNC_TIMEOUT_EN defined:
  - An 8-bit SYNC dwell counter is added.
  - If no lane locks within TIMEOUT clocks of entering ST_SYNC: sync_err pulse, go to ST_IDLE.
- MIPI_SYNC_TIMEOUT_EN undefined: no counter, and ST_SYNC waits indefinitely until LP exit.

## Structure
- Package mipi_pkg holds the state encodings ST_IDLE..ST_STREAM and the default SYNC_BYTE constant.
- Sub-module mipi_lane_sync: one per lane, generated. It contains the window registers, polarity XOR, offset search, lock, and skew FIFO.
- The top level holds the LP synchronizer, FSM, counters and output register.

## Test plan
- 2 lanes, zero skew, offset 3, hs_settle=5, LP 00 held → sof with data=16'hB8B8, then the payload bytes in order with we=1.
- 4 lanes, lane 2 lags 3 clocks, SKEW_DEPTH=4 → output bytes aligned and sof 2 clocks after lane 2's match.
- Lane lag of 4 clocks, SKEW_DEPTH=4 → sync_err pulse, we stays 0, FSM back in ST_IDLE.
- lane_polarity=2'b01 with lane 0 driving inverted 8'h47 → lock succeeds and data[7:0]=8'hB8 at sof.
- LP goes 11 after 10 stream words → we=0 exactly 3 clocks after the LP edge. resetb asserted mid-burst → outputs 0 immediately.
- With MIPI_SYNC_TIMEOUT_EN, TIMEOUT=20, no sync byte → sync_err 20 clocks after entering ST_SYNC.

Source files
------------

// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI D-PHY HS lane aligner: FSM state encodings
// and the default HS leader sync pattern.
package mipi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SYNC   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

endpackage

// File: rtl/mipi_lane_sync.sv
// Per-lane HS sync search and deskew. Keeps a two-word window of deserializer
// output, finds the sync byte at any bit offset, latches that offset and
// pushes aligned bytes into a small skew FIFO that the top level drains in
// lockstep across all lanes.
module mipi_lane_sync
    import mipi_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int         SKEW_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic [7:0] q_in,
    input  logic       pol,
    input  logic       search,
    input  logic       clear,
    input  logic       pop,
    output logic       match,
    output logic       locked,
    output logic [7:0] head
);

    localparam int PW = (SKEW_DEPTH > 1) ? $clog2(SKEW_DEPTH) : 1;

    logic [7:0]    q0, q1;
    logic [15:0]   win;
    logic [15:0]   win_sh;
    logic [2:0]    off, hit_off, sel;
    logic          hit;
    logic          wen;
    logic [7:0]    wbyte;
    logic [7:0]    mem [SKEW_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // Two-word window: older word lands in the upper byte.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            q0 <= q_in;
            q1 <= q0;
        end
    end

    assign win = {q1, q0} ^ {16{pol}};

    // Scan offsets high to low so the lowest matching offset is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_off = '0;
        for (int s = 7; s >= 0; s--) begin
            if (win[15-s -: 8] == SYNC_BYTE) begin
                hit     = 1'b1;
                hit_off = 3'(s);
            end
        end
    end

    assign match  = search & ~locked & hit;
    assign wen    = (locked | match) & ~clear;
    assign sel    = locked ? off : hit_off;
    // Byte at offset sel is win[15-sel -: 8], i.e. the window shifted down by 8-sel.
    assign win_sh = win >> (5'd8 - 5'(sel));
    assign wbyte  = win_sh[7:0];
    assign head   = mem[rd_ptr];

    // Lock and offset latch; the first match freezes the bit alignment.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            locked <= 1'b0;
            off    <= '0;
        end else if (clear) begin
            locked <= 1'b0;
            off    <= '0;
        end else if (match) begin
            locked <= 1'b1;
            off    <= hit_off;
        end
    end

    // FIFO pointers; depth is a power of two so they wrap naturally.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wen) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written after lock.
    always_ff @(posedge clk) begin
        if (wen) mem[wr_ptr] <= wbyte;
    end

endmodule

// File: rtl/mipi_lane_aligner.sv
// Multi-lane MIPI D-PHY HS receive aligner. Synchronizes the LP levels,
// waits out the HS settle time, lets every lane find its sync byte, absorbs
// inter-lane skew in the per-lane FIFOs and streams lane-aligned words.
// Optional MIPI_SYNC_TIMEOUT_EN adds a SYNC dwell limit (TIMEOUT clocks with
// no lane locked aborts the attempt with sync_err).
module mipi_lane_aligner
    import mipi_pkg::*;
#(
`ifdef MIPI_SYNC_TIMEOUT_EN
    parameter int         TIMEOUT    = 255,
`endif
    parameter int         NUM_LANES  = 2,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int         SKEW_DEPTH = 4,
    parameter int         SETTLE_W   = 8
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic [NUM_LANES*8-1:0] q_in,
    input  logic [NUM_LANES-1:0]   lp_p,
    input  logic [NUM_LANES-1:0]   lp_n,
    input  logic [NUM_LANES-1:0]   lane_polarity,
    input  logic [SETTLE_W-1:0]    hs_settle,
    output logic                   we,
    output logic [NUM_LANES*8-1:0] data,
    output logic                   sof,
    output logic                   sync_err
);

    localparam int SKW = $clog2(SKEW_DEPTH) + 1;

    state_t                 state, state_nxt;
    logic [NUM_LANES-1:0]   lp_p_s1, lp_p_s2, lp_n_s1, lp_n_s2;
    logic                   lp00;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic [SKW-1:0]         skew_cnt;
    logic                   first;
    logic [NUM_LANES-1:0]   match, locked;
    logic [NUM_LANES*8-1:0] heads;
    logic                   all_ok, any_act, skew_exp, tmo, abort, we_nxt;

    // LP levels idle high, so the synchronizer resets to LP-11.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lp_p_s1 <= '1;
            lp_p_s2 <= '1;
            lp_n_s1 <= '1;
            lp_n_s2 <= '1;
        end else begin
            lp_p_s1 <= lp_p;
            lp_p_s2 <= lp_p_s1;
            lp_n_s1 <= lp_n;
            lp_n_s2 <= lp_n_s1;
        end
    end

    assign lp00 = ~|{lp_p_s2, lp_n_s2};

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        mipi_lane_sync #(
            .SYNC_BYTE  (SYNC_BYTE),
            .SKEW_DEPTH (SKEW_DEPTH)
        ) u_lane (
            .clk    (clk),
            .resetb (resetb),
            .q_in   (q_in[8*k +: 8]),
            .pol    (lane_polarity[k]),
            .search (state == ST_SYNC),
            .clear  (state == ST_IDLE),
            .pop    (state == ST_STREAM),
            .match  (match[k]),
            .locked (locked[k]),
            .head   (heads[8*k +: 8])
        );
    end

    // A lane counts as locked in the cycle it matches, so a simultaneous
    // lock of every lane goes straight to streaming.
    assign all_ok   = &(locked | match);
    assign any_act  = |(locked | match);
    assign skew_exp = any_act && !all_ok && (skew_cnt == SKW'(SKEW_DEPTH - 1));

`ifdef MIPI_SYNC_TIMEOUT_EN
    logic [7:0] dwell_cnt;

    // SYNC dwell counter, cleared whenever the FSM is outside ST_SYNC.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)               dwell_cnt <= '0;
        else if (state == ST_SYNC) dwell_cnt <= dwell_cnt + 8'd1;
        else                       dwell_cnt <= '0;
    end

    assign tmo = !any_act && (dwell_cnt == 8'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; LP exit always wins over alignment outcomes.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lp00) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!lp00)                         state_nxt = ST_IDLE;
                else if (settle_cnt == hs_settle)  state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!lp00)       state_nxt = ST_IDLE;
                else if (all_ok) state_nxt = ST_STREAM;
                else if (skew_exp || tmo) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (!lp00) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Settle and skew counters; skew timer runs from the first lock.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            settle_cnt <= '0;
            skew_cnt   <= '0;
            first      <= 1'b1;
        end else begin
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            skew_cnt   <= (state == ST_SYNC && any_act) ? skew_cnt + 1'b1 : '0;
            first      <= (state != ST_STREAM);
        end
    end

    assign we_nxt = (state == ST_STREAM) && lp00;

    // Output register; data is forced to zero whenever we is low.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            we       <= 1'b0;
            sof      <= 1'b0;
            data     <= '0;
            sync_err <= 1'b0;
        end else begin
            we       <= we_nxt;
            sof      <= we_nxt && first;
            data     <= we_nxt ? heads : '0;
            sync_err <= abort;
        end
    end

endmodule

// File: tb/tb_mipi_lane_aligner.sv
// Self-checking bench for mipi_lane_aligner: directed and randomized HS
// bursts with per-lane bit offset, skew and polarity, checked cycle by cycle
// against expectations derived from the burst description.
module tb_mipi_lane_aligner;
    import mipi_pkg::*;

    localparam int NL = 4;
    localparam int SD = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic [NL*8-1:0] q_in = '0;
    logic [NL-1:0] lp_p = '1, lp_n = '1;
    logic [NL-1:0] lane_polarity = '0;
    logic [SW-1:0] hs_settle = '0;
    logic          we, sof, sync_err;
    logic [NL*8-1:0] data;

    int total = 0;
    int bad = 0;

    logic [7:0] xs [NL][64];
    int         lag_a [NL];
    int         off_a [NL];
    logic [NL-1:0] pol_v;

    mipi_lane_aligner #(
`ifdef MIPI_SYNC_TIMEOUT_EN
        .TIMEOUT    (20),
`endif
        .NUM_LANES  (NL),
        .SYNC_BYTE  (8'hB8),
        .SKEW_DEPTH (SD),
        .SETTLE_W   (SW)
    ) dut (
        .clk           (clk),
        .resetb        (resetb),
        .q_in          (q_in),
        .lp_p          (lp_p),
        .lp_n          (lp_n),
        .lane_polarity (lane_polarity),
        .hs_settle     (hs_settle),
        .we            (we),
        .data          (data),
        .sof           (sof),
        .sync_err      (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        lp_p = '1;
        lp_n = '1;
        q_in = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One HS burst. Lane k sends zeros, then the sync byte at byte index
    // 8+lag, then random payload, serialized at bit offset off_a[k].
    // Lane k matches in window cycle L+2; output starts 2 cycles after the
    // last match. A lag spread of SD aborts SD cycles after the first match.
    task automatic run_burst(input int hs, input int nw, input bit ok, input int rst_at);
        int lk [NL];
        int minl, maxl, e2, tend, errc, sofc;
        logic [15:0] t;
        logic [7:0] prev;
        logic [NL*8-1:0] exp_d;
        logic exp_we;
        minl = 99;
        maxl = 0;
        for (int k = 0; k < NL; k++) begin
            lk[k] = 8 + lag_a[k];
            if (lk[k] < minl) minl = lk[k];
            if (lk[k] > maxl) maxl = lk[k];
            for (int j = 0; j < 64; j++)
                xs[k][j] = (j < lk[k]) ? 8'h00 : (j == lk[k]) ? SYNC_BYTE_DEF : 8'($urandom);
        end
        sofc = maxl + 4;
        errc = minl + 2 + SD;
        e2   = ok ? maxl + 1 + nw : minl + 6;
        tend = e2 + 6;
        hs_settle = SW'(hs);
        lane_polarity = pol_v;
        for (int j = 0; j < tend; j++) begin
            lp_p = (j < e2) ? '0 : '1;
            lp_n = (j < e2) ? '0 : '1;
            for (int k = 0; k < NL; k++) begin
                prev = (j == 0) ? 8'h00 : xs[k][j-1];
                t = {prev, xs[k][j]};
                q_in[8*k +: 8] = t[7+off_a[k] -: 8] ^ {8{pol_v[k]}};
            end
            if (j == rst_at) begin
                resetb = 1'b0;
                #1;
                chk("rst_we", we, 0);
                chk("rst_sof", sof, 0);
                chk("rst_data", data, 0);
                chk("rst_sync_err", sync_err, 0);
                lp_p = '1;
                lp_n = '1;
                @(posedge clk);
                #1;
                resetb = 1'b1;
                return;
            end
            exp_we = ok && (j >= sofc) && (j <= e2 + 2);
            exp_d = '0;
            if (exp_we)
                for (int k = 0; k < NL; k++) exp_d[8*k +: 8] = xs[k][lk[k] + j - sofc];
            chk($sformatf("we@%0d", j), we, exp_we);
            chk($sformatf("sof@%0d", j), sof, ok && (j == sofc));
            chk($sformatf("data@%0d", j), data, exp_d);
            chk($sformatf("sync_err@%0d", j), sync_err, !ok && (j == errc));
            if (!ok && j == errc) chk("state_after_err", dut.state, ST_IDLE);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lanes(input int l0, l1, l2, l3, input int o0, o1, o2, o3, input logic [NL-1:0] p);
        lag_a[0] = l0; lag_a[1] = l1; lag_a[2] = l2; lag_a[3] = l3;
        off_a[0] = o0; off_a[1] = o1; off_a[2] = o2; off_a[3] = o3;
        pol_v = p;
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < NL; k++) begin
            lag_a[k] = $urandom_range(3, 0);
            off_a[k] = $urandom_range(7, 0);
        end
        pol_v = NL'($urandom);
    endtask

    initial begin
        #12;
        chk("reset_we", we, 0);
        chk("reset_sof", sof, 0);
        chk("reset_data", data, 0);
        chk("reset_sync_err", sync_err, 0);
        chk("reset_state", dut.state, ST_IDLE);
        resetb = 1'b1;
        @(posedge clk);
        #1;
        idle(4);

        // zero skew, offset 3, settle 5
        set_lanes(0, 0, 0, 0, 3, 3, 3, 3, 4'b0000);
        run_burst(5, 10, 1'b1, -1);
        idle(4);

        // lane 2 lags by the maximum tolerated skew
        set_lanes(0, 0, 3, 0, 1, 6, 2, 7, 4'b0000);
        run_burst(2, 8, 1'b1, -1);
        idle(4);

        // lane 2 lags one clock too many
        set_lanes(0, 0, 4, 0, 0, 5, 4, 2, 4'b0000);
        run_burst(1, 5, 1'b0, -1);
        idle(4);

        // lane 0 inverted on the wire (sends 8'h47)
        set_lanes(0, 0, 0, 0, 0, 2, 0, 5, 4'b0001);
        run_burst(0, 6, 1'b1, -1);
        idle(4);

        for (int i = 0; i < 8; i++) begin
            rand_lanes();
            run_burst($urandom_range(6, 0), $urandom_range(12, 1), 1'b1, -1);
            idle(4);
        end

        // reset in the middle of a stream, then a clean burst
        rand_lanes();
        run_burst(3, 10, 1'b1, 8 + 3 + 4 + 3);
        idle(4);
        rand_lanes();
        run_burst(4, 7, 1'b1, -1);
        idle(4);

`ifdef MIPI_SYNC_TIMEOUT_EN
        // no sync byte at all: SYNC entered at cycle 6 with hs_settle=2
        hs_settle = SW'(2);
        q_in = '0;
        for (int j = 0; j < 30; j++) begin
            lp_p = (j < 27) ? '0 : '1;
            lp_n = (j < 27) ? '0 : '1;
            chk($sformatf("tmo_sync_err@%0d", j), sync_err, j == 26);
            chk($sformatf("tmo_we@%0d", j), we, 0);
            @(posedge clk);
            #1;
        end
        idle(4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
